// File: rtl/keypad_scan_ctrl.sv
// 4x4 active-low keypad scanner with debounce, 3x3 key-code decode and a small event FIFO.
// Optional auto-repeat while a key is held: define KEYPAD_REPEAT_EN.
module keypad_scan_ctrl #(
  parameter int unsigned DEBOUNCE_CNT  = 3,
  parameter int unsigned FIFO_DEPTH    = 4,
  parameter int unsigned REPEAT_DELAY  = 50,
  parameter int unsigned REPEAT_PERIOD = 20
) (
  input  logic       clk_100Hz,
  input  logic       reset,
  input  logic [3:0] keypadCol,
  output logic [3:0] keypadRow,
  output logic       key_valid,
  output logic [3:0] key_code,
  input  logic       key_ready,
  output logic       key_held,
  output logic       overflow
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam logic [3:0]  DB_LAST  = 4'(DEBOUNCE_CNT - 1);
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(FIFO_DEPTH);

  if (DEBOUNCE_CNT < 2 || DEBOUNCE_CNT > 15 || FIFO_DEPTH < 2 || FIFO_DEPTH > 16 ||
      (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || REPEAT_DELAY == 0 || REPEAT_PERIOD == 0) begin : g_bad_cfg
    $error("keypad_scan_ctrl: invalid parameter set");
  end

  typedef enum logic [1:0] {SCAN, DEBOUNCE, HELD} state_t;

  state_t      state_q;
  logic [1:0]  row_q, col_q, row_nxt, hit_col;
  logic [3:0]  row_drv_q, code_q, cnt_q, rel_q, hit_code;
  logic        held_q, ovf_q, hit, col_low, push;

  logic [3:0]  mem_q [FIFO_DEPTH];
  logic [AW-1:0] rd_q, wr_q;
  logic [AW:0] count_q;
  logic [3:0]  last_q;
  logic        pop, full, do_push;

`ifdef KEYPAD_REPEAT_EN
  localparam logic [15:0] DLY_LAST = 16'(REPEAT_DELAY - 1);
  localparam logic [15:0] PER_LAST = 16'(REPEAT_PERIOD - 1);
  logic [15:0] rep_cnt_q;
  logic        rep_phase_q, rep_hit;
  assign rep_hit = (state_q == HELD) && col_low &&
                   (rep_cnt_q == (rep_phase_q ? PER_LAST : DLY_LAST));
`endif

  // Lowest-index low column on rows 0..2 wins; row 3 and column 3 never hit.
  always_comb begin
    hit     = 1'b0;
    hit_col = '0;
    if (row_q != 2'd3) begin
      if (!keypadCol[0]) begin
        hit = 1'b1; hit_col = 2'd0;
      end else if (!keypadCol[1]) begin
        hit = 1'b1; hit_col = 2'd1;
      end else if (!keypadCol[2]) begin
        hit = 1'b1; hit_col = 2'd2;
      end
    end
  end

  assign hit_code = {2'b00, row_q} * 4'd3 + {2'b00, hit_col};
  assign row_nxt  = row_q + 2'd1;
  assign col_low  = ~keypadCol[col_q];

  always_comb begin
    push = (state_q == DEBOUNCE) && col_low && (cnt_q == DB_LAST);
`ifdef KEYPAD_REPEAT_EN
    if (rep_hit) push = 1'b1;
`endif
  end

  always_ff @(posedge clk_100Hz or negedge reset) begin
    if (!reset) begin
      state_q   <= SCAN;
      row_q     <= '0;
      row_drv_q <= 4'b1110;
      col_q     <= '0;
      code_q    <= '0;
      cnt_q     <= '0;
      rel_q     <= '0;
      held_q    <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
      rep_cnt_q   <= '0;
      rep_phase_q <= 1'b0;
`endif
    end else begin
      case (state_q)
        SCAN: begin
          if (hit) begin
            code_q  <= hit_code;
            col_q   <= hit_col;
            cnt_q   <= 4'd1;
            held_q  <= 1'b1;
            state_q <= DEBOUNCE;
          end else begin
            row_q     <= row_nxt;
            row_drv_q <= ~(4'b0001 << row_nxt);
          end
        end
        DEBOUNCE: begin
          if (col_low) begin
            if (cnt_q == DB_LAST) begin
              cnt_q   <= '0;
              rel_q   <= '0;
              state_q <= HELD;
`ifdef KEYPAD_REPEAT_EN
              rep_cnt_q   <= '0;
              rep_phase_q <= 1'b0;
`endif
            end else begin
              cnt_q <= cnt_q + 4'd1;
            end
          end else begin
            cnt_q     <= '0;
            held_q    <= 1'b0;
            row_q     <= row_nxt;
            row_drv_q <= ~(4'b0001 << row_nxt);
            state_q   <= SCAN;
          end
        end
        HELD: begin
          if (!col_low) begin
            // Repeat timing is frozen while a release is being qualified.
            if (rel_q == DB_LAST) begin
              rel_q     <= '0;
              held_q    <= 1'b0;
              row_q     <= row_nxt;
              row_drv_q <= ~(4'b0001 << row_nxt);
              state_q   <= SCAN;
            end else begin
              rel_q <= rel_q + 4'd1;
            end
          end else begin
            rel_q <= '0;
`ifdef KEYPAD_REPEAT_EN
            if (rep_hit) begin
              rep_cnt_q   <= '0;
              rep_phase_q <= 1'b1;
            end else begin
              rep_cnt_q <= rep_cnt_q + 16'd1;
            end
`endif
          end
        end
        default: state_q <= SCAN;
      endcase
    end
  end

  assign key_valid = (count_q != '0);
  assign full      = (count_q == FULL_CNT);
  assign pop       = key_valid & key_ready;
  assign do_push   = push & (~full | pop);

  always_ff @(posedge clk_100Hz or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      rd_q    <= '0;
      wr_q    <= '0;
      count_q <= '0;
      last_q  <= '0;
      ovf_q   <= 1'b0;
    end else begin
      if (do_push) begin
        mem_q[wr_q] <= code_q;
        wr_q        <= wr_q + 1'b1;
      end
      if (pop) begin
        last_q <= mem_q[rd_q];
        rd_q   <= rd_q + 1'b1;
      end
      if (do_push && !pop)      count_q <= count_q + 1'b1;
      else if (!do_push && pop) count_q <= count_q - 1'b1;
      if (push && full && !pop) ovf_q <= 1'b1;
    end
  end

  assign key_code  = key_valid ? mem_q[rd_q] : last_q;
  assign keypadRow = row_drv_q;
  assign key_held  = held_q;
  assign overflow  = ovf_q;

endmodule
